// File: rtl/ram_block_be.sv
// Simple dual-port RAM with per-byte write enables, a 1- or 2-cycle registered
// read path with valid flag, selectable read-during-write policy and post-reset clear.
module ram_block_be #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 128,
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             write_en,
   input  logic [ADDR_WIDTH-1:0]            write_addr,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             read_en,
   input  logic [ADDR_WIDTH-1:0]            read_addr,
   output logic [DATA_WIDTH-1:0]            q,
   output logic                             q_valid,
   output logic                             init_busy
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("ram_block_be: READ_LATENCY must be 1 or 2");
   end
   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("ram_block_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

   // Lanes with byte_en set take new data, the rest keep the old word.
   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [NB-1:0]         lane_en
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_word;
      for (int i = 0; i < NB; i++) begin
         if (lane_en[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return res;
   endfunction

   state_t                  state;
   state_t                  state_nxt;
   logic [ADDR_WIDTH-1:0]   clr_cnt;
   logic                    wr_acc;
   logic                    rd_acc;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   rd_fwd;
   logic [DATA_WIDTH-1:0]   data_p0;
   logic                    vld_p0;
   logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RESET_STATE;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      init_busy = 1'b0;
      if (CLEAR_ON_RESET == 0) begin
         state_nxt = ST_RUN;
      end else if (state == ST_CLEAR) begin
         init_busy = 1'b1;
         if (clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = ST_RUN;
      end
   end

   assign wr_acc = write_en && !init_busy;
   assign rd_acc = read_en && !init_busy;

   // Storage: clear sweep has priority; user writes are lane-masked.
   always_ff @(posedge clk) begin
      if (init_busy) begin
         mem[clr_cnt] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (byte_en[i]) mem[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   always_comb begin
      rd_word = mem[read_addr];
      rd_fwd  = rd_word;
      if (RDW_MODE != 0 && wr_acc && (write_addr == read_addr)) begin
         rd_fwd = merge_lanes(rd_word, data_in, byte_en);
      end
   end

   // Stage p0: array read; data only advances on an accepted read so q holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p0 <= '0;
         vld_p0  <= 1'b0;
      end else begin
         vld_p0 <= rd_acc;
         if (rd_acc) data_p0 <= rd_fwd;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] data_p1;
      logic                  vld_p1;

      // Stage p1: retiming register, copies p0 every cycle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
         end else begin
            data_p1 <= data_p0;
            vld_p1  <= vld_p0;
         end
      end

      assign q       = data_p1;
      assign q_valid = vld_p1;
   end else begin : g_lat1
      assign q       = data_p0;
      assign q_valid = vld_p0;
   end

endmodule

// File: tb/tb_ram_block_be.sv
// Directed bench for ram_block_be: two instances share stimulus, A is latency 1 / old-data,
// B is latency 2 / new-data; both clear a 16-entry array after reset.
module tb_ram_block_be;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        write_en = 1'b0;
   logic [3:0]  write_addr = '0;
   logic [3:0]  byte_en = '0;
   logic [31:0] data_in = '0;
   logic        read_en = 1'b0;
   logic [3:0]  read_addr = '0;

   logic [31:0] q_a, q_b;
   logic        v_a, v_b, busy_a, busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_block_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(1),
                  .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
      .byte_en(byte_en), .data_in(data_in), .read_en(read_en), .read_addr(read_addr),
      .q(q_a), .q_valid(v_a), .init_busy(busy_a));

   ram_block_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(2),
                  .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
      .byte_en(byte_en), .data_in(data_in), .read_en(read_en), .read_addr(read_addr),
      .q(q_b), .q_valid(v_b), .init_busy(busy_b));

   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [3:0]  be;
      logic [31:0] din;
      logic        re;
      logic [3:0]  ra;
      logic [31:0] q_old;
      logic [31:0] q_new;
      logic        v;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [3:0] be,
                               input logic [31:0] din, input logic re, input logic [3:0] ra,
                               input logic [31:0] q_old, input logic [31:0] q_new, input logic v);
      vec_t r;
      r.we = we; r.wa = wa; r.be = be; r.din = din; r.re = re; r.ra = ra;
      r.q_old = q_old; r.q_new = q_new; r.v = v;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      write_en = 1'b0; read_en = 1'b0; byte_en = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles with init_busy high (bounded) and notes any valid pulse meanwhile.
   task automatic wait_clear(output int cycles, output bit saw_v, output bit busy_diff);
      cycles = 0; saw_v = 0; busy_diff = 0;
      while (busy_a && cycles < 100) begin
         if (v_a || v_b) saw_v = 1;
         if (busy_a !== busy_b) busy_diff = 1;
         tick();
         cycles++;
      end
      if (v_a || v_b) saw_v = 1;
      if (busy_a !== busy_b) busy_diff = 1;
   endtask

   int cycles;
   bit saw_v, busy_diff;

   initial begin
      vecs[0]  = mk(1, 4'd3,  4'hF, 32'hAABBCCDD, 0, 4'd0,  32'h0,        32'h0,        0);
      vecs[1]  = mk(1, 4'd3,  4'h5, 32'h11223344, 0, 4'd0,  32'h0,        32'h0,        0);
      vecs[2]  = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd3,  32'hAA22CC44, 32'hAA22CC44, 1);
      vecs[3]  = mk(1, 4'd7,  4'h3, 32'hFFFFFFFF, 1, 4'd7,  32'h00000000, 32'h0000FFFF, 1);
      vecs[4]  = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd7,  32'h0000FFFF, 32'h0000FFFF, 1);
      vecs[5]  = mk(1, 4'd9,  4'hF, 32'h12345678, 0, 4'd0,  32'h0000FFFF, 32'h0000FFFF, 0);
      vecs[6]  = mk(1, 4'd9,  4'h0, 32'hDEADBEEF, 1, 4'd9,  32'h12345678, 32'h12345678, 1);
      vecs[7]  = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd9,  32'h12345678, 32'h12345678, 1);
      vecs[8]  = mk(1, 4'd0,  4'hF, 32'h01010101, 0, 4'd0,  32'h12345678, 32'h12345678, 0);
      vecs[9]  = mk(1, 4'd1,  4'hF, 32'h02020202, 1, 4'd0,  32'h01010101, 32'h01010101, 1);
      vecs[10] = mk(1, 4'd2,  4'hF, 32'h03030303, 1, 4'd1,  32'h02020202, 32'h02020202, 1);
      vecs[11] = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd2,  32'h03030303, 32'h03030303, 1);
      vecs[12] = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd0,  32'h01010101, 32'h01010101, 1);
      vecs[13] = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd1,  32'h02020202, 32'h02020202, 1);
      vecs[14] = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd2,  32'h03030303, 32'h03030303, 1);
      vecs[15] = mk(0, 4'd0,  4'h0, 32'h0,        0, 4'd0,  32'h03030303, 32'h03030303, 0);
      vecs[16] = mk(1, 4'd15, 4'h8, 32'hCAFEF00D, 1, 4'd15, 32'h00000000, 32'hCA000000, 1);
      vecs[17] = mk(0, 4'd0,  4'h0, 32'h0,        1, 4'd15, 32'hCA000000, 32'hCA000000, 1);
      vecs[18] = mk(0, 4'd0,  4'h0, 32'h0,        0, 4'd0,  32'hCA000000, 32'hCA000000, 0);

      // Reset values
      repeat (3) tick();
      chk("rst_q_a", q_a, 32'h0);
      chk("rst_v_a", {31'b0, v_a}, 32'h0);
      chk("rst_busy_a", {31'b0, busy_a}, 32'h1);
      chk("rst_q_b", q_b, 32'h0);
      chk("rst_v_b", {31'b0, v_b}, 32'h0);
      chk("rst_busy_b", {31'b0, busy_b}, 32'h1);

      // Requests during the clear sweep must be dropped
      write_en = 1'b1; write_addr = 4'd5; byte_en = 4'hF; data_in = 32'hFFFFFFFF;
      read_en = 1'b1; read_addr = 4'd5;
      rst_n = 1'b1;
      wait_clear(cycles, saw_v, busy_diff);
      idle_inputs();
      chk("busy_cycles", cycles, 32'd16);
      chk("busy_a_vs_b", {31'b0, busy_diff}, 32'h0);
      tick();
      if (v_a || v_b) saw_v = 1;
      chk("no_valid_while_busy", {31'b0, saw_v}, 32'h0);

      read_en = 1'b1; read_addr = 4'd5;
      tick();
      read_en = 1'b0;
      chk("rd5_v_a", {31'b0, v_a}, 32'h1);
      chk("rd5_q_a", q_a, 32'h0);
      chk("rd5_early_v_b", {31'b0, v_b}, 32'h0);
      tick();
      chk("rd5_v_b", {31'b0, v_b}, 32'h1);
      chk("rd5_q_b", q_b, 32'h0);
      chk("rd5_pulse_a", {31'b0, v_a}, 32'h0);

      // Table: A checked after the same edge, B one edge later
      for (int i = 0; i < NV; i++) begin
         write_en = vecs[i].we; write_addr = vecs[i].wa; byte_en = vecs[i].be;
         data_in = vecs[i].din; read_en = vecs[i].re; read_addr = vecs[i].ra;
         tick();
         chk($sformatf("vec%0d_v_a", i), {31'b0, v_a}, {31'b0, vecs[i].v});
         chk($sformatf("vec%0d_q_a", i), q_a, vecs[i].q_old);
         if (i > 0) begin
            chk($sformatf("vec%0d_v_b", i-1), {31'b0, v_b}, {31'b0, vecs[i-1].v});
            chk($sformatf("vec%0d_q_b", i-1), q_b, vecs[i-1].q_new);
         end
      end
      idle_inputs();
      tick();
      chk("vec18_v_b", {31'b0, v_b}, {31'b0, vecs[NV-1].v});
      chk("vec18_q_b", q_b, vecs[NV-1].q_new);

      // Reset with two reads in flight
      read_en = 1'b1; read_addr = 4'd2;
      tick();
      read_addr = 4'd1;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_q_a", q_a, 32'h0);
      chk("midrst_v_a", {31'b0, v_a}, 32'h0);
      chk("midrst_q_b", q_b, 32'h0);
      chk("midrst_v_b", {31'b0, v_b}, 32'h0);
      chk("midrst_busy", {31'b0, busy_a}, 32'h1);
      idle_inputs();
      saw_v = 0;
      repeat (2) begin
         tick();
         if (v_a || v_b) saw_v = 1;
      end
      rst_n = 1'b1;
      begin
         bit sv2;
         wait_clear(cycles, sv2, busy_diff);
         saw_v = saw_v | sv2;
      end
      chk("rebusy_cycles", cycles, 32'd16);
      chk("rebusy_a_vs_b", {31'b0, busy_diff}, 32'h0);
      chk("no_late_valid", {31'b0, saw_v}, 32'h0);

      // Clear ran again: address 3 reads back zero
      read_en = 1'b1; read_addr = 4'd3;
      tick();
      read_en = 1'b0;
      chk("reclr_v_a", {31'b0, v_a}, 32'h1);
      chk("reclr_q_a", q_a, 32'h0);
      tick();
      chk("reclr_v_b", {31'b0, v_b}, 32'h1);
      chk("reclr_q_b", q_b, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
